hwpe_stream_tcdm_arbiter: RTL and testbench
===========================================

HWPE_STREAM_TCDM_ARBITER -- requirements
Module: hwpe_stream_tcdm_arbiter

Interface
REQ-001 SHALL have parameter NB_REQ, default 2, meaning number of requesters sharing one TCDM port (2..8).
REQ-002 SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive grants to one locked owner (1..16).
REQ-003 SHALL have parameter ID_W, default $clog2(NB_REQ), meaning the owner index width (minimum 1).
REQ-004 SHALL use one clock, clk_i; reset rst_ni is asynchronous and active-low.
REQ-005 Ports, in this order:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- clear_i  in  1  sync soft clear
- in_req_i  in  NB_REQ  per-requester req
- in_add_i  in  NB_REQ*32  per-requester address
- in_wen_i  in  NB_REQ  per-requester wen (1=read)
- in_be_i  in  NB_REQ*4  per-requester byte enable
- in_data_i  in  NB_REQ*32  per-requester write data
- in_gnt_o  out  NB_REQ  per-requester grant
- in_r_valid_o  out  NB_REQ  per-requester response valid
- in_r_data_o  out  32  response data, broadcast to all requesters
- out_req_o  out  1  shared-port req
- out_add_o  out  32  shared-port address
- out_wen_o  out  1  shared-port wen
- out_be_o  out  4  shared-port byte enable
- out_data_o  out  32  shared-port write data
- out_gnt_i  in  1  shared-port grant
- out_r_valid_i  in  1  shared-port response valid, exactly 1 cycle after grant
- out_r_data_i  in  32  shared-port response data
- owner_o  out  ID_W  current winner index
- locked_o  out  1  burst lock active

Function
REQ-006 State SHALL be: rr_ptr (ID_W), lock (1), owner (ID_W), burst_cnt (5 bits), r_pending (1), r_owner (ID_W).
REQ-007 Winner selection (combinational):
- if lock=1 and in_req_i[owner]=1, the winner SHALL be owner;
- otherwise the winner SHALL be the first requesting index scanning rr_ptr, rr_ptr+1, ... modulo NB_REQ;
- with no request, the winner SHALL be rr_ptr.
REQ-008 out_req_o SHALL equal OR of in_req_i; out_add/wen/be/data SHALL be the winner's fields with zero latency.
REQ-009 in_gnt_o[i] SHALL equal out_gnt_i & out_req_o & (winner==i); all other bits SHALL be 0.
REQ-010 A handshake is out_req_o & out_gnt_i; on each handshake the block SHALL register r_pending=1 and r_owner=winner, otherwise r_pending=0.
REQ-011 in_r_valid_o[i] SHALL equal out_r_valid_i & r_pending & (r_owner==i); in_r_data_o SHALL equal out_r_data_i.
REQ-012 Lock FSM states are UNLOCKED and LOCKED.
- UNLOCKED->LOCKED on a handshake when MAX_BURST>1: set owner=winner and burst_cnt=1.
- LOCKED, handshake, burst_cnt<MAX_BURST-1: stay LOCKED and increment burst_cnt.
- LOCKED, handshake, burst_cnt==MAX_BURST-1: go UNLOCKED and set rr_ptr=(owner+1) mod NB_REQ.
- LOCKED with in_req_i[owner]=0: go UNLOCKED and set rr_ptr=(owner+1) mod NB_REQ; a handshake by another winner in that same cycle SHALL enter LOCKED for that winner instead.
- With MAX_BURST=1, every handshake SHALL set rr_ptr=(winner+1) mod NB_REQ and lock SHALL stay 0.
REQ-013 With no handshake and the owner still requesting (out_gnt_i=0), state SHALL hold; no starvation timeout SHALL exist.
REQ-014 rr_ptr wrap SHALL be modulo NB_REQ, including non-power-of-2 NB_REQ.
REQ-015 owner_o SHALL equal winner and locked_o SHALL equal lock.

Reset
REQ-016 On rst_ni=0 (async): rr_ptr=0, lock=0, owner=0, burst_cnt=0, r_pending=0, r_owner=0, giving all in_gnt_o=0, in_r_valid_o=0, locked_o=0, owner_o=0.
REQ-017 clear_i=1 SHALL synchronously apply the REQ-016 values in the same cycle, overriding any handshake update.
REQ-018 A response arriving the cycle after a clear SHALL be dropped (in_r_valid_o all 0).
REQ-019 Combinational paths SHALL remain live during clear_i.

Verification
REQ-020 Reset, then in_req_i=2'b11, out_gnt_i=1, MAX_BURST=4 -> grants to req0 for 4 cycles, then req1 for 4, alternating; locked_o=1 from cycle 2.
REQ-021 NB_REQ=3, MAX_BURST=1, all requesting, gnt=1 -> grant order 0,1,2,0,1,2; rr_ptr wraps 2->0.
REQ-022 Owner req0 reads 0x100 and then drops req while req1 requests -> in_r_valid_o=01 with data the cycle after, next grant goes to req1, lock re-established for 1.
REQ-023 out_gnt_i=0 for 5 cycles while locked -> no in_gnt_o, burst_cnt/owner unchanged, same winner granted when out_gnt_i returns.
REQ-024 clear_i pulsed on a handshake cycle -> next cycle r_pending=0, in_r_valid_o=0 despite out_r_valid_i=1, rr_ptr=0, locked_o=0.
REQ-025 rst_ni asserted mid-burst (burst_cnt=2) -> outputs immediately at reset values; after release, arbitration restarts from req0.

Source files
------------

// File: rtl/hwpe_stream_tcdm_arbiter.sv
// hwpe_stream_tcdm_arbiter
// Shares one TCDM port among NB_REQ requesters. A requester that wins a
// handshake keeps the port for up to MAX_BURST consecutive grants while it
// keeps requesting; otherwise arbitration is round-robin from rr_ptr.
//
// Ports
//   clk_i, rst_ni         clock, async active-low reset
//   clear_i               synchronous soft clear of all state
//   in_*_i / in_*_o       per-requester TCDM request side (packed per lane)
//   in_r_data_o           response data, broadcast to every requester
//   out_*_o / out_*_i     shared TCDM port (response 1 cycle after grant)
//   owner_o               current winner index
//   locked_o              burst lock active

// Per-requester decode of grant and response valid.
module hwpe_stream_tcdm_arbiter_lane #(
  parameter int unsigned ID_W = 1,
  parameter int unsigned IDX  = 0
) (
  input  logic            hs_i,
  input  logic [ID_W-1:0] winner_i,
  input  logic            rsp_i,
  input  logic [ID_W-1:0] r_owner_i,
  output logic            gnt_o,
  output logic            r_valid_o
);
  localparam logic [ID_W-1:0] MY_ID = ID_W'(IDX);

  assign gnt_o     = hs_i  & (winner_i  == MY_ID);
  assign r_valid_o = rsp_i & (r_owner_i == MY_ID);
endmodule

module hwpe_stream_tcdm_arbiter #(
  parameter int unsigned NB_REQ    = 2,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned ID_W      = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic [NB_REQ-1:0]       in_req_i,
  input  logic [NB_REQ-1:0][31:0] in_add_i,
  input  logic [NB_REQ-1:0]       in_wen_i,
  input  logic [NB_REQ-1:0][3:0]  in_be_i,
  input  logic [NB_REQ-1:0][31:0] in_data_i,
  output logic [NB_REQ-1:0]       in_gnt_o,
  output logic [NB_REQ-1:0]       in_r_valid_o,
  output logic [31:0]             in_r_data_o,
  output logic                    out_req_o,
  output logic [31:0]             out_add_o,
  output logic                    out_wen_o,
  output logic [3:0]              out_be_o,
  output logic [31:0]             out_data_o,
  input  logic                    out_gnt_i,
  input  logic                    out_r_valid_i,
  input  logic [31:0]             out_r_data_i,
  output logic [ID_W-1:0]         owner_o,
  output logic                    locked_o
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

  localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NB_REQ - 1);
  localparam logic [4:0]      BURST_LAST = 5'(MAX_BURST - 1);

  // Increment modulo NB_REQ; explicit wrap so non-power-of-2 counts work.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == LAST_ID) ? '0 : id + ID_W'(1);
  endfunction

  lock_state_e     lock_q, lock_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [4:0]      burst_cnt_q, burst_cnt_d;
  logic            r_pending_q, r_pending_d;
  logic [ID_W-1:0] r_owner_q, r_owner_d;

  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] scan_idx;
  logic            found;
  logic            hs;

  // Winner: locked owner if still requesting, else first requester from rr_ptr.
  always_comb begin
    winner   = rr_ptr_q;
    found    = 1'b0;
    scan_idx = rr_ptr_q;
    if (lock_q == LOCKED && in_req_i[owner_q]) begin
      winner = owner_q;
      found  = 1'b1;
    end
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      if (!found && in_req_i[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
      scan_idx = next_id(scan_idx);
    end
  end

  assign out_req_o = |in_req_i;
  assign hs        = out_req_o & out_gnt_i;

  // Zero-latency forward of the winner's request fields.
  always_comb begin
    out_add_o  = '0;
    out_wen_o  = 1'b0;
    out_be_o   = '0;
    out_data_o = '0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        out_add_o  = in_add_i[i];
        out_wen_o  = in_wen_i[i];
        out_be_o   = in_be_i[i];
        out_data_o = in_data_i[i];
      end
    end
  end

  for (genvar g = 0; g < NB_REQ; g++) begin : g_lane
    hwpe_stream_tcdm_arbiter_lane #(
      .ID_W (ID_W),
      .IDX  (g)
    ) i_lane (
      .hs_i      (hs),
      .winner_i  (winner),
      .rsp_i     (out_r_valid_i & r_pending_q),
      .r_owner_i (r_owner_q),
      .gnt_o     (in_gnt_o[g]),
      .r_valid_o (in_r_valid_o[g])
    );
  end

  assign in_r_data_o = out_r_data_i;
  assign owner_o     = winner;
  assign locked_o    = (lock_q == LOCKED);

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    r_pending_d = hs;
    r_owner_d   = hs ? winner : r_owner_q;

    if (MAX_BURST == 1) begin
      if (hs) rr_ptr_d = next_id(winner);
    end else begin
      // Owner gave up the port: release; a handshake below may re-lock
      // onto the new winner in the same cycle.
      if (lock_q == LOCKED && !in_req_i[owner_q]) begin
        lock_d      = UNLOCKED;
        rr_ptr_d    = next_id(owner_q);
        burst_cnt_d = '0;
      end
      if (hs) begin
        if (lock_q == LOCKED && winner == owner_q) begin
          if (burst_cnt_q < BURST_LAST) begin
            burst_cnt_d = burst_cnt_q + 5'd1;
          end else begin
            lock_d      = UNLOCKED;
            rr_ptr_d    = next_id(owner_q);
            burst_cnt_d = '0;
          end
        end else begin
          lock_d      = LOCKED;
          owner_d     = winner;
          burst_cnt_d = 5'd1;
        end
      end
    end

    // Soft clear wins over any handshake update; also drops the response
    // expected next cycle.
    if (clear_i) begin
      rr_ptr_d    = '0;
      lock_d      = UNLOCKED;
      owner_d     = '0;
      burst_cnt_d = '0;
      r_pending_d = 1'b0;
      r_owner_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      lock_q      <= UNLOCKED;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      r_pending_q <= 1'b0;
      r_owner_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      r_pending_q <= r_pending_d;
      r_owner_q   <= r_owner_d;
    end
  end

endmodule

// File: tb/tb_hwpe_stream_tcdm_arbiter.sv
module tb_hwpe_stream_tcdm_arbiter;
  localparam int NB = 3;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             clear_i = 1'b0;
  logic [NB-1:0]    in_req_i = '0;
  logic [NB-1:0][31:0] in_add_i = '0;
  logic [NB-1:0]    in_wen_i = '0;
  logic [NB-1:0][3:0] in_be_i = '0;
  logic [NB-1:0][31:0] in_data_i = '0;
  logic             out_gnt_i = 1'b0;
  logic             out_r_valid_i = 1'b0;
  logic [31:0]      out_r_data_i = '0;

  // DUT A: burst lock of 4; DUT B: plain round-robin (MAX_BURST=1)
  logic [NB-1:0] gnt_a, rv_a, gnt_b, rv_b;
  logic [31:0]   rdata_a, rdata_b, add_a, add_b, data_a, data_b;
  logic          req_a, req_b, wen_a, wen_b, lk_a, lk_b;
  logic [3:0]    be_a, be_b;
  logic [1:0]    own_a, own_b;

  always #5 clk_i = ~clk_i;

  hwpe_stream_tcdm_arbiter #(.NB_REQ(NB), .MAX_BURST(4)) u_dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .in_req_i(in_req_i), .in_add_i(in_add_i), .in_wen_i(in_wen_i),
    .in_be_i(in_be_i), .in_data_i(in_data_i),
    .in_gnt_o(gnt_a), .in_r_valid_o(rv_a), .in_r_data_o(rdata_a),
    .out_req_o(req_a), .out_add_o(add_a), .out_wen_o(wen_a),
    .out_be_o(be_a), .out_data_o(data_a),
    .out_gnt_i(out_gnt_i), .out_r_valid_i(out_r_valid_i), .out_r_data_i(out_r_data_i),
    .owner_o(own_a), .locked_o(lk_a));

  hwpe_stream_tcdm_arbiter #(.NB_REQ(NB), .MAX_BURST(1)) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .in_req_i(in_req_i), .in_add_i(in_add_i), .in_wen_i(in_wen_i),
    .in_be_i(in_be_i), .in_data_i(in_data_i),
    .in_gnt_o(gnt_b), .in_r_valid_o(rv_b), .in_r_data_o(rdata_b),
    .out_req_o(req_b), .out_add_o(add_b), .out_wen_o(wen_b),
    .out_be_o(be_b), .out_data_o(data_b),
    .out_gnt_i(out_gnt_i), .out_r_valid_i(out_r_valid_i), .out_r_data_i(out_r_data_i),
    .owner_o(own_b), .locked_o(lk_b));

  // Reference model: 'left' counts grants still allowed in the current burst.
  typedef struct { int rr; bit lk; int own; int left; bit pend; int rown; } mst_t;
  typedef struct {
    logic [NB-1:0] gnt, rv; int own; logic lk, req, wen;
    logic [31:0] add, data, rdata; logic [3:0] be;
  } exp_t;

  localparam mst_t RST = '{rr: 0, lk: 0, own: 0, left: 0, pend: 0, rown: 0};

  mst_t sa, sb;
  exp_t qa[$], qb[$];
  int n_cmp = 0, n_err = 0;

  function automatic int pick(mst_t s, logic [NB-1:0] req);
    if (s.lk && req[s.own]) return s.own;
    for (int k = 0; k < NB; k++) if (req[(s.rr + k) % NB]) return (s.rr + k) % NB;
    return s.rr;
  endfunction

  function automatic mst_t step(mst_t s, int mb, logic [NB-1:0] req, bit gnt, bit clr);
    mst_t n = s;
    int w = pick(s, req);
    bit hs = (req != 0) && gnt;
    n.pend = hs;
    if (hs) n.rown = w;
    if (mb == 1) begin
      if (hs) n.rr = (w + 1) % NB;
    end else begin
      if (s.lk && !req[s.own]) begin n.lk = 0; n.rr = (s.own + 1) % NB; end
      if (hs) begin
        if (s.lk && w == s.own) begin
          n.left = s.left - 1;
          if (n.left == 0) begin n.lk = 0; n.rr = (s.own + 1) % NB; end
        end else begin
          n.lk = 1; n.own = w; n.left = mb - 1;
        end
      end
    end
    if (clr) n = RST;
    return n;
  endfunction

  function automatic exp_t mk_exp(mst_t s);
    exp_t e;
    int w = pick(s, in_req_i);
    e.req = (in_req_i != 0);
    e.gnt = '0;
    if (e.req && out_gnt_i) e.gnt[w] = 1'b1;
    e.rv = '0;
    if (out_r_valid_i && s.pend) e.rv[s.rown] = 1'b1;
    e.own = w; e.lk = s.lk;
    e.add = in_add_i[w]; e.wen = in_wen_i[w]; e.be = in_be_i[w]; e.data = in_data_i[w];
    e.rdata = out_r_data_i;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expected snapshot per cycle per DUT, compared mid-cycle.
  always @(negedge clk_i) begin
    if (qa.size() > 0 && qb.size() > 0) begin
      exp_t ea, eb;
      ea = qa.pop_front();
      eb = qb.pop_front();
      chk("a_gnt", 64'(gnt_a), 64'(ea.gnt));
      chk("a_rvalid", 64'(rv_a), 64'(ea.rv));
      chk("a_owner", 64'(own_a), 64'(ea.own));
      chk("a_locked", 64'(lk_a), 64'(ea.lk));
      chk("a_req", 64'(req_a), 64'(ea.req));
      chk("a_fields", {add_a, data_a}, {ea.add, ea.data});
      chk("a_wen_be", 64'({wen_a, be_a}), 64'({ea.wen, ea.be}));
      chk("a_rdata", 64'(rdata_a), 64'(ea.rdata));
      chk("b_gnt", 64'(gnt_b), 64'(eb.gnt));
      chk("b_rvalid", 64'(rv_b), 64'(eb.rv));
      chk("b_owner", 64'(own_b), 64'(eb.own));
      chk("b_locked", 64'(lk_b), 64'(eb.lk));
      chk("b_fields", {add_b, data_b}, {eb.add, eb.data});
    end
  end

  task automatic cycle(input logic [NB-1:0] req, input bit gnt, input bit rv,
                       input bit clr, input bit rst);
    @(posedge clk_i); #1;
    rst_ni   = !rst;
    in_req_i = req;
    for (int i = 0; i < NB; i++) begin
      in_add_i[i]  = $urandom;
      in_data_i[i] = $urandom;
      in_be_i[i]   = 4'($urandom_range(0, 15));
      in_wen_i[i]  = 1'($urandom_range(0, 1));
    end
    out_gnt_i     = gnt;
    out_r_valid_i = rv;
    out_r_data_i  = $urandom;
    clear_i       = clr;
    if (rst) begin sa = RST; sb = RST; end
    #1;
    qa.push_back(mk_exp(sa));
    qb.push_back(mk_exp(sb));
    if (!rst) begin
      sa = step(sa, 4, req, gnt, clr);
      sb = step(sb, 1, req, gnt, clr);
    end
  endtask

  initial begin
    sa = RST; sb = RST;
    cycle('0, 0, 1, 0, 1);            // reset state, response suppressed
    cycle('0, 0, 0, 0, 1);
    // two requesters, always granted: 4-grant bursts alternating
    for (int i = 0; i < 12; i++) cycle(3'b011, 1, i > 0, 0, 0);
    // all requesting: round-robin / burst across three
    for (int i = 0; i < 9; i++) cycle(3'b111, 1, 1, 0, 0);
    // stall while locked, then resume
    cycle(3'b011, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(3'b011, 0, 0, 0, 0);
    cycle(3'b011, 1, 0, 0, 0);
    // owner drops request mid-burst while another requests
    cycle(3'b001, 1, 1, 0, 0);
    cycle(3'b010, 1, 1, 0, 0);
    cycle(3'b010, 1, 1, 0, 0);
    // clear on a handshake cycle, response next cycle must be dropped
    cycle(3'b110, 1, 1, 1, 0);
    cycle(3'b110, 1, 1, 0, 0);
    // async reset mid-burst
    cycle(3'b011, 1, 1, 0, 0);
    cycle(3'b011, 1, 1, 0, 0);
    cycle(3'b011, 0, 1, 0, 1);
    cycle(3'b011, 1, 1, 0, 0);
    // randomized traffic
    for (int i = 0; i < 600; i++)
      cycle(3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 40) == 0, i == 300);
    @(posedge clk_i);
    @(negedge clk_i); #1;
    chk("queue_drained", 64'(qa.size() + qb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
